// File: rtl/axi_wr_slv_mem.sv
// axi_wr_slv_mem: AXI4 write-channel slave storing bursts in a word memory and returning B responses
// Ports: aclk/arst_n clock and async active-low reset; aw* write address channel (queued);
// w* write data channel; b* write response channel; dbg_addr/dbg_rdata registered debug
// read of the memory (1-cycle latency); err_cnt saturating count of non-OKAY responses.
module axi_wr_slv_mem #(
    parameter int DW        = 128,
    parameter int AW        = 32,
    parameter int IDW       = 4,
    parameter int MEM_DEPTH = 256,
    parameter int AQ_DEPTH  = 4
) (
    input  logic                         aclk,
    input  logic                         arst_n,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [IDW-1:0]               awid,
    input  logic [AW-1:0]                awaddr,
    input  logic [5:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [IDW-1:0]               wid,
    input  logic [DW-1:0]                wdata,
    input  logic [DW/8-1:0]              wstrb,
    input  logic                         wlast,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [IDW-1:0]               bid,
    output logic [1:0]                   bresp,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DW-1:0]                dbg_rdata,
    output logic [15:0]                  err_cnt
);
    localparam int BL  = $clog2(DW/8);
    localparam int IW  = AW - BL;
    localparam int QW  = $clog2(AQ_DEPTH);
    localparam int DAW = $clog2(MEM_DEPTH);
    localparam int EW  = IDW + IW + 11;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    aq_q [AQ_DEPTH];
    logic [QW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [QW:0]      aq_cnt_q, aq_cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [5:0]       len_q, len_d, beat_q, beat_d;
    logic             fixed_q, fixed_d, nowr_q, nowr_d;
    logic [1:0]       err_q, err_d;
    logic             wready_q, wready_d, bvalid_q, bvalid_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [DW-1:0]    mem [MEM_DEPTH];
    logic [DW-1:0]    dbg_rdata_q;
    logic [EW-1:0]    head;
    logic [1:0]       beat_err;
    logic             push, pop, beat, oor, last_cnt, bad, wr_en;
    logic             unused_addr_lsb;

    // Byte offset within a word carries no meaning for a word-addressed memory.
    assign unused_addr_lsb = ^awaddr[BL-1:0];

    assign awready   = aq_cnt_q != (QW+1)'(AQ_DEPTH);
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = id_q;
    assign bresp     = err_q;
    assign dbg_rdata = dbg_rdata_q;
    assign err_cnt   = err_cnt_q;

    // Queue entry layout: {id, word index, len, size, burst}.
    assign head     = aq_q[rp_q];
    assign push     = awvalid && awready;
    assign pop      = state_q == IDLE && aq_cnt_q != '0;
    assign bad      = head[1] || head[4:2] != 3'(BL);
    assign beat     = wvalid && wready_q;
    assign oor      = idx_q >= IW'(MEM_DEPTH);
    assign last_cnt = beat_q == len_q;
    // Response codes are ordered so that OR-ing keeps the highest-priority error.
    assign beat_err = (oor ? 2'b11 : 2'b00) | ((wid != id_q || wlast != last_cnt) ? 2'b10 : 2'b00);
    assign wr_en    = beat && !nowr_q && !oor;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        idx_d     = idx_q;
        len_d     = len_q;
        beat_d    = beat_q;
        fixed_d   = fixed_q;
        nowr_d    = nowr_q;
        err_d     = err_q;
        wp_d      = push ? wp_q + 1'b1 : wp_q;
        rp_d      = pop ? rp_q + 1'b1 : rp_q;
        aq_cnt_d  = aq_cnt_q + (QW+1)'(push) - (QW+1)'(pop);
        case (state_q)
            IDLE: if (pop) begin
                id_d    = head[EW-1 -: IDW];
                idx_d   = head[EW-IDW-1 -: IW];
                len_d   = head[10:5];
                fixed_d = head[1:0] == 2'b00;
                nowr_d  = bad;
                err_d   = bad ? 2'b10 : 2'b00;
                beat_d  = '0;
                state_d = DATA;
            end
            DATA: if (beat) begin
                err_d   = err_q | beat_err;
                beat_d  = beat_q + 1'b1;
                idx_d   = fixed_q ? idx_q : idx_q + 1'b1;
                state_d = (last_cnt || wlast) ? RESP : DATA;
            end
            RESP: state_d = bready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        wready_d  = state_d == DATA;
        bvalid_d  = state_d == RESP;
        err_cnt_d = (bvalid_q && bready && err_q != 2'b00 && err_cnt_q != 16'hFFFF) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            aq_cnt_q    <= '0;
            id_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            fixed_q     <= 1'b0;
            nowr_q      <= 1'b0;
            err_q       <= 2'b00;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            err_cnt_q   <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            aq_cnt_q    <= aq_cnt_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            fixed_q     <= fixed_d;
            nowr_q      <= nowr_d;
            err_q       <= err_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            err_cnt_q   <= err_cnt_d;
            dbg_rdata_q <= mem[dbg_addr];
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            aq_q[wp_q] <= {awid, awaddr[AW-1:BL], awlen, awsize, awburst};
        for (int i = 0; i < DW/8; i++)
            if (wr_en && wstrb[i])
                mem[idx_q[DAW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
    end
endmodule
